// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the fifo_datos data FIFO.
// Default geometry and reset values of the occupancy thresholds.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  localparam int TH_ALTO_RST = FIFO_DEPTH - 1;
  localparam int TH_BAJO_RST = 1;

  // Almost-full reset threshold for a FIFO of arbitrary depth.
  function automatic int th_alto_rst_for(input int depth);
    return depth - FIFO_DEPTH + TH_ALTO_RST;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one registered read port.
// Storage is not reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a full-FIFO read+write is safe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_datos.sv
// fifo_datos: synchronous data FIFO with programmable almost-full/empty flags.
// Optional sticky underflow flag enabled by FIFO_UNDERFLOW_EN.
module fifo_datos
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_Fifo,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  empty_Fifo,
  output logic                  no_empty_Fifo,
`ifdef FIFO_UNDERFLOW_EN
  output logic                  Fifo_overflow,
  output logic                  Fifo_underflow
`else
  output logic                  Fifo_overflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] TH_ALTO_INI =
    (ADDR_WIDTH+1)'(th_alto_rst_for(DEPTH));
  localparam logic [ADDR_WIDTH:0] TH_BAJO_INI =
    (ADDR_WIDTH+1)'(TH_BAJO_RST);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   th_alto;
  logic [ADDR_WIDTH:0]   th_bajo;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf;

  assign full  = (count == FULL_C);
  assign empty = (count == '0);

  // On a full FIFO a paired pop frees the slot the write lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_alto <= TH_ALTO_INI;
      th_bajo <= TH_BAJO_INI;
    end else if (init) begin
      th_alto <= umbral_alto;
      th_bajo <= umbral_bajo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (init) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

`ifdef FIFO_UNDERFLOW_EN
  logic unf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unf <= 1'b0;
    end else if (init) begin
      unf <= 1'b0;
    end else if (pop && empty && !push) begin
      unf <= 1'b1;
    end
  end

  assign Fifo_underflow = unf;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_en;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (data_Fifo)
  );

  assign fifo_count    = count;
  assign almost_full   = (count >= th_alto);
  assign almost_empty  = (count <= th_bajo);
  assign empty_Fifo    = empty;
  assign no_empty_Fifo = !empty;
  assign Fifo_overflow = ovf;

endmodule

// File: tb/tb_fifo_datos.sv
// tb_fifo_datos: queue-model scoreboard plus directed literal checks.
// Builds with or without FIFO_UNDERFLOW_EN.
module tb_fifo_datos;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [AW:0]   umbral_alto = '0;
  logic [AW:0]   umbral_bajo = '0;
  logic          push = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_Fifo;
  logic          valid_out;
  logic [AW:0]   fifo_count;
  logic          almost_full;
  logic          almost_empty;
  logic          empty_Fifo;
  logic          no_empty_Fifo;
  logic          Fifo_overflow;
`ifdef FIFO_UNDERFLOW_EN
  logic          Fifo_underflow;
`endif

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  fifo_datos #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .umbral_alto    (umbral_alto),
    .umbral_bajo    (umbral_bajo),
    .push           (push),
    .data_in        (data_in),
    .pop            (pop),
    .data_Fifo      (data_Fifo),
    .valid_out      (valid_out),
    .fifo_count     (fifo_count),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .empty_Fifo     (empty_Fifo),
    .no_empty_Fifo  (no_empty_Fifo),
`ifdef FIFO_UNDERFLOW_EN
    .Fifo_overflow  (Fifo_overflow),
    .Fifo_underflow (Fifo_underflow)
`else
    .Fifo_overflow  (Fifo_overflow)
`endif
  );

  // Behavioural model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;
  int            m_ta;
  int            m_tb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_data = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ta = DEPTH - 1;
      m_tb = 1;
    end else begin
      int n;
      bit rd;
      bit wr;
      n = q.size();
      rd = pop && (n > 0);
      wr = push && ((n < DEPTH) || rd);
      if (init) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_ta = int'(umbral_alto);
        m_tb = int'(umbral_bajo);
      end else begin
        if (push && n == DEPTH && !pop) m_ovf = 1'b1;
        if (pop && n == 0 && !push) m_unf = 1'b1;
      end
      m_valid = rd;
      if (rd) m_data = q.pop_front();
      if (wr) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("count", int'(fifo_count), q.size());
      chk("empty", int'(empty_Fifo), int'(q.size() == 0));
      chk("no_empty", int'(no_empty_Fifo), int'(q.size() != 0));
      chk("almost_full", int'(almost_full), int'(q.size() >= m_ta));
      chk("almost_empty", int'(almost_empty), int'(q.size() <= m_tb));
      chk("overflow", int'(Fifo_overflow), int'(m_ovf));
      chk("valid_out", int'(valid_out), int'(m_valid));
      chk("data_Fifo", int'(data_Fifo), int'(m_data));
`ifdef FIFO_UNDERFLOW_EN
      chk("underflow", int'(Fifo_underflow), int'(m_unf));
`endif
    end
  end

  // One cycle: drive after a negedge, sample at the next negedge.
  task automatic cyc(input bit p, input bit r, input logic [DW-1:0] d,
                     input bit in = 1'b0);
    push = p;
    pop = r;
    data_in = d;
    init = in;
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    init = 1'b0;
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_count"}, int'(fifo_count), 0);
    chk({tag, "_empty"}, int'(empty_Fifo), 1);
    chk({tag, "_noempty"}, int'(no_empty_Fifo), 0);
    chk({tag, "_ae"}, int'(almost_empty), 1);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_ovf"}, int'(Fifo_overflow), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_data"}, int'(data_Fifo), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_lits("rst");
    reset = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);

    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    cyc(0, 0, 8'h00, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 8'(i));
      if (i == 2) chk("ae_after2", int'(almost_empty), 1);
      if (i == 3) chk("ae_after3", int'(almost_empty), 0);
      if (i == 5) chk("af_after5", int'(almost_full), 0);
      if (i == 6) chk("af_after6", int'(almost_full), 1);
    end
    chk("count6", int'(fifo_count), 6);

    cyc(1, 0, 8'h07);
    cyc(1, 0, 8'h08);
    cyc(1, 0, 8'hAA);
    chk("ovf_set", int'(Fifo_overflow), 1);
    chk("count_full", int'(fifo_count), 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00);
      chk("pop_order", int'(data_Fifo), i);
    end
    cyc(0, 0, 8'h00, 1);
    chk("ovf_clr", int'(Fifo_overflow), 0);

    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h10 + i));
    cyc(1, 1, 8'h55);
    chk("full_rw_data", int'(data_Fifo), 8'h10);
    chk("full_rw_count", int'(fifo_count), 8);
    chk("full_rw_ovf", int'(Fifo_overflow), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00);
    chk("last_55", int'(data_Fifo), 8'h55);

    cyc(1, 1, 8'h33);
    chk("empty_rw_valid", int'(valid_out), 0);
    chk("empty_rw_count", int'(fifo_count), 1);
    cyc(0, 1, 8'h00);
    chk("pop_33", int'(data_Fifo), 8'h33);
`ifdef FIFO_UNDERFLOW_EN
    cyc(0, 1, 8'h00);
    chk("unf_set", int'(Fifo_underflow), 1);
    cyc(0, 0, 8'h00, 1);
    chk("unf_clr", int'(Fifo_underflow), 0);
`endif

    // init racing an overflowing push
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h40 + i));
    cyc(1, 0, 8'hEE, 1);
    chk("init_wins", int'(Fifo_overflow), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00);

    cyc(1, 0, 8'h80);
    for (int i = 1; i <= 20; i++) cyc(1, 1, 8'(8'h80 + i));
    chk("wrap_data", int'(data_Fifo), 8'h93);
    cyc(0, 1, 8'h00);
    chk("wrap_last", int'(data_Fifo), 8'h94);

    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hC0 + i));
    cyc(0, 1, 8'h00);
    chk("pre_rst_count", int'(fifo_count), 4);
    cyc(1, 0, 8'hC5);
    #3;
    reset = 1'b0;
    #1;
    reset_lits("async");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_datos.md
# fifo_datos

Parameterised synchronous FIFO that buffers the 8-bit data stream and produces the occupancy flags consumed by the flow-control FSM directly downstream: `almost_full`, `almost_empty`, `empty_Fifo`, `no_empty_Fifo` and `Fifo_overflow`. The almost-full and almost-empty thresholds are programmable and latched on `init`, so the FSM sees status that already reflects its configured limits. Read data goes out on `data_Fifo`, the same bus the FSM observes.

## Interface
- `DATA_WIDTH`, 8: width of a stored word.
- `DEPTH`, 8: number of entries; must be a power of two, and at least 4.
- `ADDR_WIDTH`, 3: log2(`DEPTH`); pointer width. The count is `ADDR_WIDTH+1` bits wide.

- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `init`: input, 1 bit. Synchronous pulse; latches the thresholds and clears `Fifo_overflow`.
- `umbral_alto`: input, `ADDR_WIDTH+1` bits. Almost-full threshold; sampled only when `init`=1.
- `umbral_bajo`: input, `ADDR_WIDTH+1` bits. Almost-empty threshold; sampled only when `init`=1.
- `push`: input, 1 bit. Write request.
- `data_in`: input, `DATA_WIDTH` bits. Write data.
- `pop`: input, 1 bit. Read request.
- `data_Fifo`: output, `DATA_WIDTH` bits. Registered read data.
- `valid_out`: output, 1 bit. `data_Fifo` is valid this cycle.
- `fifo_count`: output, `ADDR_WIDTH+1` bits. Current occupancy.
- `almost_full`: output, 1 bit. High when `fifo_count` >= the latched high threshold.
- `almost_empty`: output, 1 bit. High when `fifo_count` <= the latched low threshold.
- `empty_Fifo`: output, 1 bit. High when `fifo_count` == 0.
- `no_empty_Fifo`: output, 1 bit. Always `~empty_Fifo`.
- `Fifo_overflow`: output, 1 bit. Sticky flag: a write was dropped because the FIFO was full.

## Operation
- Storage: a `DEPTH` x `DATA_WIDTH` register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each `ADDR_WIDTH` bits. Pointers wrap naturally from `DEPTH-1` to 0.
- Occupancy: `count` register, `ADDR_WIDTH+1` bits, range 0..`DEPTH`. Full means `count`==`DEPTH`.
- Cases per cycle, let `w` be an accepted write and `r` an accepted read:
  - push only, not full: write at `wr_ptr`, `wr_ptr`+1, `count`+1.
  - push only, full: data is dropped; pointers and count do not change; `Fifo_overflow` is set.
  - pop only, not empty: read from `rd_ptr` into `data_Fifo`, `rd_ptr`+1, `count`-1, `valid_out`=1 next cycle.
  - pop only, empty: ignored; `valid_out`=0; `data_Fifo` holds its previous value.
  - push and pop, 0 < count < `DEPTH`: both are accepted; `count` does not change.
  - push and pop, full: both are accepted. The read takes the oldest entry and the write goes into the freed slot. No overflow.
  - push and pop, empty: only the write is accepted. There is no fall-through. `valid_out`=0.
- Thresholds: internal registers `th_alto` and `th_bajo`, reset to `DEPTH-1` and 1. On `init`=1 they load `umbral_alto` and `umbral_bajo`.
- Threshold values are not range-checked. A value greater than `DEPTH` makes `almost_full` never assert.
- `init` does not flush data. If `init` and a push on a full FIFO occur in the same cycle, `init` wins and `Fifo_overflow` stays 0.
- Reset mid-operation: contents are discarded. Pointers, count and flags go to their reset values asynchronously.

## Timing
- Reset values:
  - `data_Fifo`=0, `valid_out`=0, `fifo_count`=0.
  - `empty_Fifo`=1, `no_empty_Fifo`=0.
  - `almost_empty`=1, because 0 <= 1.
  - `almost_full`=0, `Fifo_overflow`=0.
- Read latency: one cycle. The pop is sampled at edge N, and `data_Fifo`/`valid_out` are updated at edge N.
- Status flags come combinationally from the registered `count` and threshold registers only. There is no combinational path from `push`, `pop` or `init` to any output.
- Flags therefore reflect an operation one edge after it is sampled. The downstream FSM sees one cycle of status lag and must budget for it in its `umbral_alto` setting.
- `valid_out` is a single-cycle pulse per accepted read.

## Configuration
- Macro: `FIFO_UNDERFLOW_EN`.
- With the macro defined:
  - Adds an output `Fifo_underflow` (1 bit), reset to 0.
  - It is set by a pop on an empty FIFO that is not paired with a push, is sticky, and is cleared by `init`.
- Without the macro defined: the port and its logic are absent, and a pop on an empty FIFO is silently ignored.

## Structure
- Shared package `fifo_pkg` holds:
  - the default constants `FIFO_DATA_WIDTH`=8 and `FIFO_DEPTH`=8;
  - the reset threshold constants `TH_ALTO_RST` and `TH_BAJO_RST`.
- One natural sub-module, `fifo_mem`: the register array with one write port and one registered read port. Pointer, count and flag logic stay in `fifo_datos`.

## Test plan
- Reset, then idle: `empty_Fifo`=1, `no_empty_Fifo`=0, `almost_empty`=1, `almost_full`=0, `fifo_count`=0.
- `init` with alto=6 and bajo=2, then push 0x01..0x06 on consecutive cycles:
  - `almost_empty` drops after the third write;
  - `almost_full` rises after the sixth;
  - `fifo_count`=6.
- Fill to 8 entries, then a 9th push of 0xAA:
  - `Fifo_overflow`=1 and `fifo_count` stays 8;
  - popping 8 times returns the original data in order, with no 0xAA;
  - a following `init` clears `Fifo_overflow`.
- Full FIFO with push 0x55 and pop in the same cycle: the oldest word is read, `fifo_count` stays 8, `Fifo_overflow`=0, and 0x55 comes out last.
- Empty FIFO with push 0x33 and pop in the same cycle:
  - `valid_out`=0 and `fifo_count`=1;
  - the next pop returns 0x33;
  - with `FIFO_UNDERFLOW_EN` defined, a lone pop on an empty FIFO sets `Fifo_underflow`.
- Wrap-around and reset: 20 interleaved push/pop pairs return data in order across the pointer wrap. Asserting `reset` low while 5 entries are held returns every output to its reset value immediately, without waiting for a clock edge.
